// File: rtl/intersection_scheduler.sv
// Two-phase traffic-light controller with pedestrian walk; lamps and phase are Moore-decoded from state.
// Latency: lamps change the cycle after a state transition; no backpressure, inputs are level-sampled every cycle.
module intersection_scheduler #(
  parameter int G_MIN   = 8,
  parameter int G_MAX   = 32,
  parameter int Y_TIME  = 3,
  parameter int AR_TIME = 2,
  parameter int W_TIME  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       pass,
  output logic       ns_R,
  output logic       ns_G,
  output logic       ns_Y,
  output logic       ew_R,
  output logic       ew_G,
  output logic       ew_Y,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5,
    PED  = 3'd6
  } state_t;

  localparam int M1    = (G_MAX > G_MIN) ? G_MAX : G_MIN;
  localparam int M2    = (M1 > Y_TIME) ? M1 : Y_TIME;
  localparam int M3    = (M2 > AR_TIME) ? M2 : AR_TIME;
  localparam int P_MAX = (M3 > W_TIME) ? M3 : W_TIME;
  localparam int TW    = (P_MAX > 1) ? $clog2(P_MAX) : 1;

  localparam logic [TW-1:0] T_SAT  = TW'(G_MAX - 1);
  localparam logic [TW-1:0] T_GMIN = TW'(G_MIN - 1);
  localparam logic [TW-1:0] T_Y    = TW'(Y_TIME - 1);
  localparam logic [TW-1:0] T_AR   = TW'(AR_TIME - 1);
  localparam logic [TW-1:0] T_W    = TW'(W_TIME - 1);

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic            pp, pp_nxt;
  logic            last_dir, last_dir_nxt;
  logic            od;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NS_G;
      tmr      <= '0;
      pp       <= 1'b0;
      last_dir <= DIR_EW;
    end else begin
      state    <= state_nxt;
      tmr      <= tmr_nxt;
      pp       <= pp_nxt;
      last_dir <= last_dir_nxt;
    end
  end

  // last_dir records the direction whose clearance just finished, so PED hands green to the other one.
  always_comb begin
    state_nxt    = state;
    last_dir_nxt = last_dir;
    od           = 1'b0;
    case (state)
      NS_G: begin
        od = car_ew | pp;
        if (od && (tmr >= T_GMIN)) state_nxt = NS_Y;
      end
      NS_Y: if (tmr == T_Y) state_nxt = AR1;
      AR1: begin
        if (tmr == T_AR) begin
          last_dir_nxt = DIR_NS;
          state_nxt    = pp ? PED : EW_G;
        end
      end
      EW_G: begin
        od = car_ns | pp;
        if (od && (tmr >= T_GMIN)) state_nxt = EW_Y;
      end
      EW_Y: if (tmr == T_Y) state_nxt = AR2;
      AR2: begin
        if (tmr == T_AR) begin
          last_dir_nxt = DIR_EW;
          state_nxt    = pp ? PED : NS_G;
        end
      end
      PED: if (tmr == T_W) state_nxt = (last_dir == DIR_NS) ? EW_G : NS_G;
      default: state_nxt = NS_G;
    endcase
  end

  // Requests seen during the walk itself are dropped; the latch clears as the walk ends.
  always_comb begin
    pp_nxt = pp | pass;
    if (state == PED) pp_nxt = (tmr == T_W) ? 1'b0 : pp;
  end

  always_comb begin
    tmr_nxt = (tmr == T_SAT) ? tmr : tmr + 1'b1;
    if (state_nxt != state) tmr_nxt = '0;
  end

  always_comb begin
    ns_R  = 1'b1;
    ns_G  = 1'b0;
    ns_Y  = 1'b0;
    ew_R  = 1'b1;
    ew_G  = 1'b0;
    ew_Y  = 1'b0;
    walk  = 1'b0;
    phase = state;
    case (state)
      NS_G: begin ns_R = 1'b0; ns_G = 1'b1; end
      NS_Y: begin ns_R = 1'b0; ns_Y = 1'b1; end
      EW_G: begin ew_R = 1'b0; ew_G = 1'b1; end
      EW_Y: begin ew_R = 1'b0; ew_Y = 1'b1; end
      PED:  walk = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Table-driven bench for intersection_scheduler: per-cycle expected phase and pedestrian latch, scoreboard-compared.
module tb_intersection_scheduler;

  localparam logic [2:0] P_NS_G = 3'd0, P_NS_Y = 3'd1, P_AR1 = 3'd2, P_EW_G = 3'd3,
                         P_EW_Y = 3'd4, P_AR2 = 3'd5, P_PED = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       car_ns = 1'b0, car_ew = 1'b0, pass = 1'b0;
  logic       ns_R, ns_G, ns_Y, ew_R, ew_G, ew_Y, walk;
  logic [2:0] phase;

  always #5 clk = ~clk;

  intersection_scheduler dut (
    .clk(clk), .rst(rst), .car_ns(car_ns), .car_ew(car_ew), .pass(pass),
    .ns_R(ns_R), .ns_G(ns_G), .ns_Y(ns_Y), .ew_R(ew_R), .ew_G(ew_G), .ew_Y(ew_Y),
    .walk(walk), .phase(phase)
  );

  typedef struct {
    int         scen;
    int         c0;
    int         c1;
    bit         r;
    bit         cns;
    bit         cew;
    bit         ps;
    logic [2:0] ph;
    bit         pp;
  } vec_t;

  typedef struct {
    logic [2:0] ph;
    bit         pp;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; car_ns = 1'b0; car_ew = 1'b0; pass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle's inputs, queue its expectation, and compare it mid-cycle.
  task automatic step(bit r, bit cns, bit cew, bit ps, logic [2:0] ph, bit ep, string tag);
    exp_t       e;
    logic [6:0] lamps_exp;
    rst = r; car_ns = cns; car_ew = cew; pass = ps;
    e.ph = ph; e.pp = ep; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    lamps_exp = {!(e.ph == P_NS_G || e.ph == P_NS_Y), e.ph == P_NS_G, e.ph == P_NS_Y,
                 !(e.ph == P_EW_G || e.ph == P_EW_Y), e.ph == P_EW_G, e.ph == P_EW_Y,
                 e.ph == P_PED};
    chk({e.tag, "_phase"}, 32'(phase), 32'(e.ph));
    chk({e.tag, "_pp"}, 32'(dut.pp), 32'(e.pp));
    chk({e.tag, "_lamps"}, 32'({ns_R, ns_G, ns_Y, ew_R, ew_G, ew_Y, walk}), 32'(lamps_exp));
    chk({e.tag, "_onehot"}, 32'({ns_R + ns_G + ns_Y == 2'd1, ew_R + ew_G + ew_Y == 2'd1}), 32'd3);
    @(posedge clk);
    #1;
  endtask

  task automatic add(int s, int a, int b, bit r, bit cns, bit cew, bit ps, logic [2:0] ph, bit pp);
    vec_t v;
    v.scen = s; v.c0 = a; v.c1 = b; v.r = r; v.cns = cns; v.cew = cew; v.ps = ps; v.ph = ph; v.pp = pp;
    vecs.push_back(v);
  endtask

  initial begin
    int prev;
    // scen 0: constant east-west demand
    add(0,  0,  7, 0, 0, 1, 0, P_NS_G, 0);
    add(0,  8, 10, 0, 0, 1, 0, P_NS_Y, 0);
    add(0, 11, 12, 0, 0, 1, 0, P_AR1,  0);
    add(0, 13, 20, 0, 0, 1, 0, P_EW_G, 0);
    // scen 1: idle, green holds
    add(1,  0, 99, 0, 0, 0, 0, P_NS_G, 0);
    // scen 2: pass pulse at cycle 2
    add(2,  0,  1, 0, 0, 0, 0, P_NS_G, 0);
    add(2,  2,  2, 0, 0, 0, 1, P_NS_G, 0);
    add(2,  3,  7, 0, 0, 0, 0, P_NS_G, 1);
    add(2,  8, 10, 0, 0, 0, 0, P_NS_Y, 1);
    add(2, 11, 12, 0, 0, 0, 0, P_AR1,  1);
    add(2, 13, 18, 0, 0, 0, 0, P_PED,  1);
    add(2, 19, 25, 0, 0, 0, 0, P_EW_G, 0);
    // scen 3: late demand exits immediately
    add(3,  0, 19, 0, 0, 0, 0, P_NS_G, 0);
    add(3, 20, 20, 0, 0, 1, 0, P_NS_G, 0);
    add(3, 21, 23, 0, 0, 1, 0, P_NS_Y, 0);
    add(3, 24, 25, 0, 0, 1, 0, P_AR1,  0);
    add(3, 26, 28, 0, 0, 1, 0, P_EW_G, 0);
    // scen 4: pass held through PED is ignored; AR2 goes to green, not PED
    add(4,  0,  0, 0, 0, 0, 1, P_NS_G, 0);
    add(4,  1,  7, 0, 0, 0, 0, P_NS_G, 1);
    add(4,  8, 10, 0, 0, 0, 0, P_NS_Y, 1);
    add(4, 11, 12, 0, 0, 0, 0, P_AR1,  1);
    add(4, 13, 18, 0, 0, 0, 1, P_PED,  1);
    add(4, 19, 26, 0, 1, 0, 0, P_EW_G, 0);
    add(4, 27, 29, 0, 1, 0, 0, P_EW_Y, 0);
    add(4, 30, 31, 0, 1, 0, 0, P_AR2,  0);
    add(4, 32, 35, 0, 1, 0, 0, P_NS_G, 0);
    // scen 5: request during EW_G routes through AR2 -> PED -> NS_G
    add(5,  0,  7, 0, 0, 1, 0, P_NS_G, 0);
    add(5,  8, 10, 0, 0, 1, 0, P_NS_Y, 0);
    add(5, 11, 12, 0, 0, 1, 0, P_AR1,  0);
    add(5, 13, 13, 0, 0, 1, 1, P_EW_G, 0);
    add(5, 14, 20, 0, 0, 1, 0, P_EW_G, 1);
    add(5, 21, 23, 0, 0, 1, 0, P_EW_Y, 1);
    add(5, 24, 25, 0, 0, 1, 0, P_AR2,  1);
    add(5, 26, 31, 0, 0, 0, 0, P_PED,  1);
    add(5, 32, 35, 0, 0, 0, 0, P_NS_G, 0);
    // scen 6: reset during PED
    add(6,  0,  0, 0, 0, 0, 1, P_NS_G, 0);
    add(6,  1,  7, 0, 0, 0, 0, P_NS_G, 1);
    add(6,  8, 10, 0, 0, 0, 0, P_NS_Y, 1);
    add(6, 11, 12, 0, 0, 0, 0, P_AR1,  1);
    add(6, 13, 14, 0, 0, 0, 0, P_PED,  1);
    add(6, 15, 15, 1, 0, 0, 0, P_PED,  1);
    add(6, 16, 20, 0, 0, 0, 0, P_NS_G, 0);

    prev = -1;
    foreach (vecs[i]) begin
      if (vecs[i].scen != prev) begin
        do_reset();
        prev = vecs[i].scen;
      end
      for (int c = vecs[i].c0; c <= vecs[i].c1; c++)
        step(vecs[i].r, vecs[i].cns, vecs[i].cew, vecs[i].ps, vecs[i].ph, vecs[i].pp,
             $sformatf("s%0d_c%0d", vecs[i].scen, c));
    end

    // Reset pulse during EW_Y with a pending request: back to NS_G with the request discarded.
    do_reset();
    for (int c = 0; c <= 7; c++)   step(0, 0, 1, 0, P_NS_G, 0, $sformatf("rf_c%0d", c));
    for (int c = 8; c <= 10; c++)  step(0, 0, 1, 0, P_NS_Y, 0, $sformatf("rf_c%0d", c));
    for (int c = 11; c <= 12; c++) step(0, 0, 1, 0, P_AR1,  0, $sformatf("rf_c%0d", c));
    step(0, 0, 1, 0, P_EW_G, 0, "rf_c13");
    step(0, 1, 1, 1, P_EW_G, 0, "rf_c14");
    for (int c = 15; c <= 20; c++) step(0, 1, 1, 0, P_EW_G, 1, $sformatf("rf_c%0d", c));
    step(0, 1, 1, 0, P_EW_Y, 1, "rf_c21");
    step(1, 1, 1, 0, P_EW_Y, 1, "rf_c22_rst");
    for (int c = 23; c <= 26; c++) step(0, 0, 0, 0, P_NS_G, 0, $sformatf("rf_c%0d", c));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  G_MIN    8   minimum green dwell, cycles (>=1)
  G_MAX    32  maximum green dwell under opposing demand, cycles (>=G_MIN)
  Y_TIME   3   yellow duration, cycles (>=1)
  AR_TIME  2   all-red clearance duration, cycles (>=1)
  W_TIME   6   pedestrian walk duration, cycles (>=1)
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk       in   1  single clock, all state on rising edge
  rst       in   1  synchronous, active-high reset
  car_ns    in   1  vehicle waiting, north-south approach (level)
  car_ew    in   1  vehicle waiting, east-west approach (level)
  pass      in   1  pedestrian crossing request (pulse or level)
  ns_R/ns_G/ns_Y  out  1 each  north-south lamp drive
  ew_R/ew_G/ew_Y  out  1 each  east-west lamp drive
  walk      out  1  pedestrian walk lamp
  phase     out  3  current state encoding (debug)
REQ-003 All inputs SHALL be treated as synchronous to clk.
REQ-004 The block SHALL have one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-005 States SHALL be NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, PED=6; phase = state code.
REQ-006 Outputs SHALL be Moore-decoded from state: exactly one of each direction's R/G/Y high; ns_G only in NS_G, ns_Y only in NS_Y, ew_G only in EW_G, ew_Y only in EW_Y, all other lamps R; walk=1 only in PED.
REQ-007 Dwell counter tmr SHALL reset to 0 on every state entry, increment each cycle, saturate at G_MAX-1; width = ceil(log2(max parameter)).
REQ-008 Pedestrian pending bit pp SHALL set on the cycle after any cycle with pass=1 while state!=PED; pass is ignored in PED; pp clears on the last PED cycle.
REQ-009 Opposing demand SHALL be: in NS_G, od = car_ew | pp; in EW_G, od = car_ns | pp.
REQ-010 NS_G/EW_G SHALL exit to matching yellow when tmr>=G_MIN-1 and od=1; no exit before G_MIN cycles; without od the green holds indefinitely.
REQ-011 Because tmr saturates at G_MAX-1 and G_MAX>=G_MIN, any od arriving after G_MIN SHALL cause exit on that cycle; G_MAX bounds dwell when od is asserted at or before G_MIN-1... (forced exit when tmr==G_MAX-1 and od=1 regardless of other conditions).
REQ-012 NS_Y SHALL last exactly Y_TIME cycles then enter AR1; EW_Y likewise to AR2.
REQ-013 AR1 SHALL last AR_TIME cycles, then PED if pp=1 else EW_G; AR2 SHALL last AR_TIME cycles, then PED if pp=1 else NS_G.
REQ-014 PED SHALL last W_TIME cycles, then go to the green of the direction opposite the one last served (one-bit last_dir register; NS after AR2, EW after AR1).
REQ-015 pass and car inputs arriving mid-yellow or mid-all-red SHALL NOT alter those durations.
REQ-016 No green SHALL ever be entered except from AR1, AR2, PED or reset; never two greens simultaneously.

Reset
REQ-017 While rst=1 at a clock edge: state=NS_G, tmr=0, pp=0, last_dir=EW; outputs ns_G=1, ew_R=1, walk=0, phase=0 from the following cycle.
REQ-018 rst asserted mid-operation (any state, including PED) SHALL override all transitions and discard pending requests.

Verification
REQ-019 Bench SHALL cover (defaults, cycle 0 = first cycle after rst release):
  a) car_ew=1 constant -> NS_G cycles 0-7, NS_Y 8-10, AR1 11-12, EW_G from 13.
  b) No inputs for 100 cycles -> ns_G=1 throughout, phase=0, walk=0.
  c) pass pulse at cycle 2 -> pp=1 at 3; NS_Y 8-10, AR1 11-12, PED 13-18 (walk=1), EW_G from 19, pp=0 from 19.
  d) car_ew=1 asserted at cycle 20 -> NS_Y entered at cycle 21 (dwell already >G_MIN).
  e) pass held during PED only -> no re-latch; following AR does not re-enter PED.
  f) rst pulse during EW_Y -> next cycle NS_G, ew_R=1, pp=0; lamp one-hot assertion checked every cycle.
